// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with EX-stage forwarding and operand select.
// Drives the ALU operands, store data and branch/jump target for the EX slot.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_E,
  input  logic            flush_E,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] ImmExt_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] PCPlus4_D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [4:0]      Rd_D,
  input  logic            RegWrite_D,
  input  logic            MemWrite_D,
  input  logic            Jump_D,
  input  logic            Branch_D,
  input  logic            ALUSrc_D,
  input  logic [1:0]      ResultSrc_D,
  input  logic [2:0]      ALUControl_D,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] Src_A,
  output logic [XLEN-1:0] Src_B,
  output logic [2:0]      ALUControl_E,
  output logic [XLEN-1:0] WriteData_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] PCPlus4_E,
  output logic [XLEN-1:0] ImmExt_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic            RegWrite_E,
  output logic            MemWrite_E,
  output logic            Jump_E,
  output logic            Branch_E,
  output logic [1:0]      ResultSrc_E,
  output logic            valid_E
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic            valid;
  } ex_slot_t;

  ex_slot_t slot_d;
  ex_slot_t slot_q;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    slot_d             = '0;
    slot_d.rd1         = RD1_D;
    slot_d.rd2         = RD2_D;
    slot_d.imm         = ImmExt_D;
    slot_d.pc          = PC_D;
    slot_d.pc_plus4    = PCPlus4_D;
    slot_d.rs1         = Rs1_D;
    slot_d.rs2         = Rs2_D;
    slot_d.rd          = Rd_D;
    slot_d.reg_write   = RegWrite_D;
    slot_d.mem_write   = MemWrite_D;
    slot_d.jump        = Jump_D;
    slot_d.branch      = Branch_D;
    slot_d.alu_src     = ALUSrc_D;
    slot_d.result_src  = ResultSrc_D;
    slot_d.alu_control = ALUControl_D;
    slot_d.valid       = 1'b1;
  end

  // A bubble is simply the all-zero slot, so flush and reset share one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot_q <= '0;
    else if (flush_E)
      slot_q <= '0;
    else if (!stall_E)
      slot_q <= slot_d;
  end

  always_comb begin
    case (ForwardA_E)
      2'b01:   fwd_a = Result_W;
      2'b10:   fwd_a = ALUResult_M;
      default: fwd_a = slot_q.rd1;
    endcase
  end

  always_comb begin
    case (ForwardB_E)
      2'b01:   fwd_b = Result_W;
      2'b10:   fwd_b = ALUResult_M;
      default: fwd_b = slot_q.rd2;
    endcase
  end

  assign Src_A        = fwd_a;
  assign Src_B        = slot_q.alu_src ? slot_q.imm : fwd_b;
  assign WriteData_E  = fwd_b;
  assign PCTarget_E   = slot_q.pc + slot_q.imm;

  assign ALUControl_E = slot_q.alu_control;
  assign PC_E         = slot_q.pc;
  assign PCPlus4_E    = slot_q.pc_plus4;
  assign ImmExt_E     = slot_q.imm;
  assign Rs1_E        = slot_q.rs1;
  assign Rs2_E        = slot_q.rs2;
  assign Rd_E         = slot_q.rd;
  assign RegWrite_E   = slot_q.reg_write;
  assign MemWrite_E   = slot_q.mem_write;
  assign Jump_E       = slot_q.jump;
  assign Branch_E     = slot_q.branch;
  assign ResultSrc_E  = slot_q.result_src;
  assign valid_E      = slot_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an EX-slot model updated per edge by the reset/flush/stall/load
// rules, checked every falling edge, plus literal expectations for the directed cases.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_E, flush_E;
  logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic        RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D;
  logic [1:0]  ResultSrc_D;
  logic [2:0]  ALUControl_D;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ALUResult_M, Result_W;
  logic [31:0] Src_A, Src_B, WriteData_E, PCTarget_E, PC_E, PCPlus4_E, ImmExt_E;
  logic [2:0]  ALUControl_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic        RegWrite_E, MemWrite_E, Jump_E, Branch_E, valid_E;
  logic [1:0]  ResultSrc_E;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_E(stall_E), .flush_E(flush_E),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .Jump_D(Jump_D), .Branch_D(Branch_D),
    .ALUSrc_D(ALUSrc_D), .ResultSrc_D(ResultSrc_D), .ALUControl_D(ALUControl_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ALUResult_M(ALUResult_M), .Result_W(Result_W),
    .Src_A(Src_A), .Src_B(Src_B), .ALUControl_E(ALUControl_E), .WriteData_E(WriteData_E),
    .PCTarget_E(PCTarget_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .ImmExt_E(ImmExt_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Jump_E(Jump_E), .Branch_E(Branch_E),
    .ResultSrc_E(ResultSrc_E), .valid_E(valid_E)
  );

  // What the EX slot must currently hold.
  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, jump, branch, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
    logic        valid;
  } slot_t;

  slot_t m;

  function automatic slot_t from_d();
    slot_t s;
    s.rd1 = RD1_D;  s.rd2 = RD2_D;  s.imm = ImmExt_D;  s.pc = PC_D;  s.pcp4 = PCPlus4_D;
    s.rs1 = Rs1_D;  s.rs2 = Rs2_D;  s.rd = Rd_D;
    s.regwrite = RegWrite_D;  s.memwrite = MemWrite_D;  s.jump = Jump_D;
    s.branch = Branch_D;  s.alusrc = ALUSrc_D;  s.resultsrc = ResultSrc_D;
    s.aluctl = ALUControl_D;  s.valid = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] reg_val);
    if (sel == 2'b01) return Result_W;
    if (sel == 2'b10) return ALUResult_M;
    return reg_val;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] fb;
    fb = pick(ForwardB_E, m.rd2);
    check("Src_A", Src_A, pick(ForwardA_E, m.rd1));
    check("Src_B", Src_B, m.alusrc ? m.imm : fb);
    check("WriteData_E", WriteData_E, fb);
    check("PCTarget_E", PCTarget_E, m.pc + m.imm);
    check("PC_E", PC_E, m.pc);
    check("PCPlus4_E", PCPlus4_E, m.pcp4);
    check("ImmExt_E", ImmExt_E, m.imm);
    check("Rs1_E", {27'd0, Rs1_E}, {27'd0, m.rs1});
    check("Rs2_E", {27'd0, Rs2_E}, {27'd0, m.rs2});
    check("Rd_E", {27'd0, Rd_E}, {27'd0, m.rd});
    check("ctrl_E", {22'd0, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ResultSrc_E, ALUControl_E, valid_E},
          {22'd0, m.regwrite, m.memwrite, m.jump, m.branch, m.resultsrc, m.aluctl, m.valid});
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  // One rising edge; the model applies the register-update rules to the inputs held across it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n || flush_E) m = '0;
    else if (!stall_E) m = from_d();
  endtask

  initial begin
    rst_n = 1'b0;  stall_E = 1'b0;  flush_E = 1'b0;
    RD1_D = 32'd0;  RD2_D = 32'd0;  ImmExt_D = 32'd0;  PC_D = 32'd0;  PCPlus4_D = 32'd0;
    Rs1_D = 5'd0;  Rs2_D = 5'd0;  Rd_D = 5'd0;
    RegWrite_D = 1'b0;  MemWrite_D = 1'b0;  Jump_D = 1'b0;  Branch_D = 1'b0;  ALUSrc_D = 1'b0;
    ResultSrc_D = 2'd0;  ALUControl_D = 3'd0;  ForwardA_E = 2'd0;  ForwardB_E = 2'd0;
    ALUResult_M = 32'd0;  Result_W = 32'd0;
    m = '0;
    #2;
    check("reset valid_E", {31'd0, valid_E}, 32'd0);
    check("reset PC_E", PC_E, 32'd0);
    #10 rst_n = 1'b1;
    chk_en = 1'b1;

    // Plain load
    RD1_D = 32'd5;  RD2_D = 32'd7;  ALUControl_D = 3'b010;  Rd_D = 5'd1;
    PC_D = 32'h40;  PCPlus4_D = 32'h44;  Rs1_D = 5'd2;  Rs2_D = 5'd4;
    tick();
    check("load Src_A", Src_A, 32'd5);
    check("load Src_B", Src_B, 32'd7);
    check("load ALUControl_E", {29'd0, ALUControl_E}, 32'd2);
    check("load valid_E", {31'd0, valid_E}, 32'd1);

    // Immediate select and branch target with carry discarded
    ALUSrc_D = 1'b1;  ImmExt_D = 32'hFFFF_FFFC;  PC_D = 32'h10;  RD2_D = 32'd9;
    tick();
    check("imm Src_B", Src_B, 32'hFFFF_FFFC);
    check("imm WriteData_E", WriteData_E, 32'd9);
    check("imm PCTarget_E", PCTarget_E, 32'h0000_000C);

    // Same-cycle forwarding
    ALUSrc_D = 1'b0;  RD1_D = 32'd21;  RD2_D = 32'd33;
    tick();
    ForwardA_E = 2'b10;  ALUResult_M = 32'h1234;
    #1 check("fwdA mem Src_A", Src_A, 32'h1234);
    ForwardB_E = 2'b01;  Result_W = 32'hABCD;
    #1 check("fwdB wb Src_B", Src_B, 32'hABCD);
    check("fwdB wb WriteData_E", WriteData_E, 32'hABCD);
    ForwardA_E = 2'b11;
    #1 check("fwdA reserved Src_A", Src_A, 32'd21);
    ForwardB_E = 2'b11;
    #1 check("fwdB reserved Src_B", Src_B, 32'd33);
    ForwardA_E = 2'b00;  ForwardB_E = 2'b00;

    // Stall holds the slot while forwarding keeps tracking
    RegWrite_D = 1'b1;  Rd_D = 5'd3;
    tick();
    check("stall pre Rd_E", {27'd0, Rd_E}, 32'd3);
    stall_E = 1'b1;  RegWrite_D = 1'b0;  Rd_D = 5'd7;  RD1_D = 32'd99;  ForwardA_E = 2'b01;
    for (int k = 0; k < 3; k++) begin
      Result_W = 32'h100 + 32'(k);
      tick();
      check("stall Rd_E", {27'd0, Rd_E}, 32'd3);
      check("stall RegWrite_E", {31'd0, RegWrite_E}, 32'd1);
      check("stall fwd Src_A", Src_A, 32'h100 + 32'(k));
    end
    ForwardA_E = 2'b00;
    flush_E = 1'b1;
    tick();
    check("flush RegWrite_E", {31'd0, RegWrite_E}, 32'd0);
    check("flush Rd_E", {27'd0, Rd_E}, 32'd0);
    check("flush valid_E", {31'd0, valid_E}, 32'd0);
    check("flush Src_A", Src_A, 32'd0);
    check("flush Src_B", Src_B, 32'd0);
    flush_E = 1'b0;  stall_E = 1'b0;

    // Back-to-back loads appear one edge later, in order
    for (int i = 0; i < 4; i++) begin
      PC_D = 32'h100 + 32'(4 * i);  PCPlus4_D = 32'h104 + 32'(4 * i);
      Rd_D = 5'(10 + i);  RD1_D = 32'(3 * i + 1);
      tick();
      check("b2b PC_E", PC_E, 32'h100 + 32'(4 * i));
      check("b2b Rd_E", {27'd0, Rd_E}, 32'(10 + i));
      check("b2b Src_A", Src_A, 32'(3 * i + 1));
    end

    // Asynchronous reset in the middle of a stall
    stall_E = 1'b1;
    #2 rst_n = 1'b0;  m = '0;
    #1;
    check("async rst valid_E", {31'd0, valid_E}, 32'd0);
    check("async rst PC_E", PC_E, 32'd0);
    check("async rst Rd_E", {27'd0, Rd_E}, 32'd0);
    #3 rst_n = 1'b1;  stall_E = 1'b0;
    tick();
    check("post rst valid_E", {31'd0, valid_E}, 32'd1);
    check("post rst PC_E", PC_E, 32'h10C);

    // Mixed traffic checked by the model on every falling edge
    for (int n = 0; n < 40; n++) begin
      RD1_D = $urandom;  RD2_D = $urandom;  ImmExt_D = $urandom;  PC_D = $urandom;
      PCPlus4_D = PC_D + 32'd4;  Rs1_D = 5'($urandom);  Rs2_D = 5'($urandom);  Rd_D = 5'($urandom);
      {RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D} = 5'($urandom);
      ResultSrc_D = 2'($urandom);  ALUControl_D = 3'($urandom);
      ForwardA_E = 2'($urandom);  ForwardB_E = 2'($urandom);
      ALUResult_M = $urandom;  Result_W = $urandom;
      stall_E = ($urandom_range(0, 3) == 0);
      flush_E = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
